// File: rtl/frame_buffer_pkg.sv
// Shared types and default widths for the frame-buffer arbiter and its BRAM port interface.
package frame_buffer_pkg;

    localparam int unsigned FB_ADDR_W = 19;
    localparam int unsigned FB_DATA_W = 18;
    localparam int unsigned FB_STAT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DISP = 2'd1,
        WR   = 2'd2,
        PR   = 2'd3
    } owner_t;

endpackage

// File: rtl/frame_buffer_arbiter_if.sv
// Single BRAM port bundle: master side issues commands, slave side (the BRAM) returns read data.
interface frame_buffer_arbiter_if #(
    parameter int unsigned ADDR_W = frame_buffer_pkg::FB_ADDR_W,
    parameter int unsigned DATA_W = frame_buffer_pkg::FB_DATA_W
) ();

    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_wdata;
    logic [DATA_W-1:0] bram_rdata;

    modport master (
        output bram_en,
        output bram_we,
        output bram_addr,
        output bram_wdata,
        input  bram_rdata
    );

    modport slave (
        input  bram_en,
        input  bram_we,
        input  bram_addr,
        input  bram_wdata,
        output bram_rdata
    );

endinterface

// File: rtl/frame_buffer_arbiter_rd_tag_pipe.sv
// Read-return tag pipeline: carries the owner of each BRAM read for DEPTH cycles, then
// captures bram read data into the owner's output register with a one-cycle valid.
module rd_tag_pipe
    import frame_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned DATA_W = FB_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  owner_t            tag_in,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic [DATA_W-1:0] pr_data,
    output logic              pr_valid
);

    owner_t tag_q [DEPTH];
    owner_t tag_exit;

    assign tag_exit = tag_q[DEPTH-1];

    // Tag shift register, aligned so the exit tag coincides with valid bram_rdata
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= IDLE;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Data registers hold their last value between valid pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_data  <= '0;
            disp_valid <= 1'b0;
            pr_data    <= '0;
            pr_valid   <= 1'b0;
        end else begin
            disp_valid <= (tag_exit == DISP);
            pr_valid   <= (tag_exit == PR);
            if (tag_exit == DISP) begin
                disp_data <= rdata;
            end
            if (tag_exit == PR) begin
                pr_data <= rdata;
            end
        end
    end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Frame-buffer BRAM port arbiter: display reads have absolute priority, filter write/read share
// the rest round-robin. Optional stall counters are built when FRAME_BUFFER_ARB_STATS_EN is defined.
module frame_buffer_arbiter
    import frame_buffer_pkg::*;
#(
    parameter int unsigned ADDR_W       = FB_ADDR_W,
    parameter int unsigned DATA_W       = FB_DATA_W,
    parameter int unsigned BRAM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  disp_req,
    input  logic [ADDR_W-1:0]     disp_addr,
    output logic [DATA_W-1:0]     disp_data,
    output logic                  disp_valid,
    input  logic                  wr_req,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    output logic                  wr_gnt,
    input  logic                  pr_req,
    input  logic [ADDR_W-1:0]     pr_addr,
    output logic                  pr_gnt,
    output logic [DATA_W-1:0]     pr_data,
    output logic                  pr_valid,
    frame_buffer_arbiter_if.master bram
`ifdef FRAME_BUFFER_ARB_STATS_EN
    ,
    output logic [FB_STAT_W-1:0]  stat_wr_stall,
    output logic [FB_STAT_W-1:0]  stat_pr_stall
`endif
);

    owner_t winner;
    owner_t cmd_owner;
    owner_t rr_last;
    owner_t tag_in;

    // Same-cycle arbitration; rr_last names the filter client served most recently
    always_comb begin
        winner = IDLE;
        if (disp_req) begin
            winner = DISP;
        end else if (wr_req && pr_req) begin
            winner = (rr_last == PR) ? WR : PR;
        end else if (wr_req) begin
            winner = WR;
        end else if (pr_req) begin
            winner = PR;
        end
        wr_gnt = (winner == WR);
        pr_gnt = (winner == PR);
    end

    // Command stage: owner FSM and registered BRAM command
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_owner       <= IDLE;
            rr_last         <= PR;
            bram.bram_en    <= 1'b0;
            bram.bram_we    <= 1'b0;
            bram.bram_addr  <= '0;
            bram.bram_wdata <= '0;
        end else begin
            cmd_owner    <= winner;
            bram.bram_en <= (winner != IDLE);
            bram.bram_we <= (winner == WR);
            if (winner == WR || winner == PR) begin
                rr_last <= winner;
            end
            case (winner)
                DISP: bram.bram_addr <= disp_addr;
                WR: begin
                    bram.bram_addr  <= wr_addr;
                    bram.bram_wdata <= wr_data;
                end
                PR:      bram.bram_addr <= pr_addr;
                default: ;
            endcase
        end
    end

    // Writes return nothing, so they enter the return path as empty slots
    always_comb begin
        tag_in = IDLE;
        if (cmd_owner == DISP || cmd_owner == PR) begin
            tag_in = cmd_owner;
        end
    end

    rd_tag_pipe #(
        .DEPTH  (BRAM_LATENCY),
        .DATA_W (DATA_W)
    ) u_rd_tag_pipe (
        .clk        (clk),
        .reset      (reset),
        .tag_in     (tag_in),
        .rdata      (bram.bram_rdata),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .pr_data    (pr_data),
        .pr_valid   (pr_valid)
    );

`ifdef FRAME_BUFFER_ARB_STATS_EN
    // Saturating counts of cycles a filter client waits with its request up
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_wr_stall <= '0;
            stat_pr_stall <= '0;
        end else begin
            if (wr_req && !wr_gnt && stat_wr_stall != '1) begin
                stat_wr_stall <= stat_wr_stall + FB_STAT_W'(1);
            end
            if (pr_req && !pr_gnt && stat_pr_stall != '1) begin
                stat_pr_stall <= stat_pr_stall + FB_STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Self-checking bench for frame_buffer_arbiter: scenario tasks plus a randomized run scored
// against a grant-order transaction model; stall counters checked when FRAME_BUFFER_ARB_STATS_EN is set.
module tb_frame_buffer_arbiter;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 18;
    localparam int unsigned LAT    = 1;
    localparam int          M_NONE = 0;
    localparam int          M_DISP = 1;
    localparam int          M_WR   = 2;
    localparam int          M_PR   = 3;

    logic              clk;
    logic              reset;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;
    logic              pr_req;
    logic [ADDR_W-1:0] pr_addr;
    logic              pr_gnt;
    logic [DATA_W-1:0] pr_data;
    logic              pr_valid;
`ifdef FRAME_BUFFER_ARB_STATS_EN
    logic [15:0]       stat_wr_stall;
    logic [15:0]       stat_pr_stall;
`endif

    int checks = 0;
    int errors = 0;

    frame_buffer_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

    frame_buffer_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .BRAM_LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_gnt     (wr_gnt),
        .pr_req     (pr_req),
        .pr_addr    (pr_addr),
        .pr_gnt     (pr_gnt),
        .pr_data    (pr_data),
        .pr_valid   (pr_valid),
        .bram       (bif.master)
`ifdef FRAME_BUFFER_ARB_STATS_EN
        ,
        .stat_wr_stall (stat_wr_stall),
        .stat_pr_stall (stat_pr_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: latency-1 synchronous port; unwritten locations read as addr+100
    logic [DATA_W-1:0] bram_mem [int];
    logic [DATA_W-1:0] rd_q = '0;
    always @(posedge clk) begin
        if (bif.bram_en) begin
            if (bif.bram_we) begin
                bram_mem[int'(bif.bram_addr)] = bif.bram_wdata;
            end else begin
                rd_q <= bram_mem.exists(int'(bif.bram_addr)) ? bram_mem[int'(bif.bram_addr)]
                                                               : DATA_W'(bif.bram_addr + ADDR_W'(100));
            end
        end
    end
    assign bif.bram_rdata = rd_q;

    // Transaction model: grants in order, each read answered 2+LAT cycles after its grant
    typedef struct {
        int                owner;
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    exp_t              exp_q [$];
    logic [DATA_W-1:0] model_mem [int];
    int                cyc;
    bit                last_was_wr;
    int                prev_win;
    logic [DATA_W-1:0] last_disp;
    logic [DATA_W-1:0] last_pr;

    logic              e_wr_gnt, e_pr_gnt, e_en, e_we, e_disp_valid, e_pr_valid;
    logic [DATA_W-1:0] e_disp_data, e_pr_data;

    function automatic logic [DATA_W-1:0] model_rd(input logic [ADDR_W-1:0] a);
        if (model_mem.exists(int'(a))) return model_mem[int'(a)];
        return DATA_W'(a + ADDR_W'(100));
    endfunction

    task automatic model_reset();
        exp_q.delete();
        last_was_wr = 1'b0;
        prev_win    = M_NONE;
        last_disp   = '0;
        last_pr     = '0;
    endtask

    // One clock: drive inputs after the falling edge, settle, and produce this cycle's expectations
    task automatic drive_cycle(input logic d, input logic [ADDR_W-1:0] da,
                               input logic w, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                               input logic p, input logic [ADDR_W-1:0] pa);
        int   win;
        exp_t e;
        @(negedge clk);
        disp_req = d; disp_addr = da;
        wr_req = w; wr_addr = wa; wr_data = wd;
        pr_req = p; pr_addr = pa;
        #1;
        if (d)           win = M_DISP;
        else if (w && p) win = last_was_wr ? M_PR : M_WR;
        else if (w)      win = M_WR;
        else if (p)      win = M_PR;
        else             win = M_NONE;
        e_wr_gnt     = (win == M_WR);
        e_pr_gnt     = (win == M_PR);
        e_en         = (prev_win != M_NONE);
        e_we         = (prev_win == M_WR);
        e_disp_valid = 1'b0;
        e_pr_valid   = 1'b0;
        while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            if (e.owner == M_DISP) begin e_disp_valid = 1'b1; last_disp = e.data; end
            else                   begin e_pr_valid   = 1'b1; last_pr   = e.data; end
        end
        e_disp_data = last_disp;
        e_pr_data   = last_pr;
        case (win)
            M_DISP: exp_q.push_back('{M_DISP, model_rd(da), cyc + 2 + int'(LAT)});
            M_PR: begin
                exp_q.push_back('{M_PR, model_rd(pa), cyc + 2 + int'(LAT)});
                last_was_wr = 1'b0;
            end
            M_WR: begin
                model_mem[int'(wa)] = wd;
                last_was_wr = 1'b1;
            end
            default: ;
        endcase
        prev_win = win;
        cyc++;
    endtask

    task automatic idle_inputs();
        disp_req = 0; disp_addr = '0; wr_req = 0; wr_addr = '0; wr_data = '0;
        pr_req = 0; pr_addr = '0;
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        model_reset();
        repeat (n) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        model_reset();
        cyc = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({disp_valid, pr_valid, wr_gnt, pr_gnt, bif.bram_en, bif.bram_we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 000000",
                     {disp_valid, pr_valid, wr_gnt, pr_gnt, bif.bram_en, bif.bram_we});
        end
        checks++;
        if (disp_data !== '0 || pr_data !== '0 || bif.bram_addr !== '0 || bif.bram_wdata !== '0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h exp 0", disp_data, pr_data, bif.bram_addr, bif.bram_wdata);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_display_only();
        int nvalid = 0;
        for (int i = 0; i < 14; i++) begin
            drive_cycle(i < 10, ADDR_W'(i), 1'b0, '0, '0, 1'b0, '0);
            if (disp_valid === 1'b1) nvalid++;
            checks++;
            if (disp_valid !== e_disp_valid || disp_data !== e_disp_data) begin
                errors++;
                $display("FAIL disp_model cyc %0d got %b/%0d exp %b/%0d", i, disp_valid, disp_data,
                         e_disp_valid, e_disp_data);
            end
            if (i >= 3 && i < 13) begin
                checks++;
                if (disp_valid !== 1'b1 || disp_data !== DATA_W'(100 + i - 3)) begin
                    errors++;
                    $display("FAIL disp_stream cyc %0d got %b/%0d exp 1/%0d", i, disp_valid, disp_data,
                             100 + i - 3);
                end
            end
        end
        checks++;
        if (nvalid != 10) begin
            errors++;
            $display("FAIL disp_count got %0d exp 10", nvalid);
        end
    endtask

    task automatic test_contention();
        int gnt_cyc = -1;
        int we_cnt  = 0;
        for (int i = 0; i < 12; i++) begin
            drive_cycle(i < 5, ADDR_W'(i), gnt_cyc < 0, ADDR_W'('h40), DATA_W'('h155), 1'b0, '0);
            if (bif.bram_we === 1'b1) we_cnt++;
            checks++;
            if (wr_gnt !== 1'(i == 5)) begin
                errors++;
                $display("FAIL cont_gnt cyc %0d got %b exp %b", i, wr_gnt, (i == 5));
            end
            if (wr_gnt === 1'b1 && gnt_cyc < 0) gnt_cyc = i;
        end
        checks++;
        if (we_cnt != 1) begin
            errors++;
            $display("FAIL cont_we_pulses got %0d exp 1", we_cnt);
        end
    endtask

    task automatic test_round_robin();
        apply_reset(2);
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, '0, 1'b1, ADDR_W'('h20), DATA_W'(i), 1'b1, ADDR_W'('h21));
            checks++;
            if (wr_gnt !== 1'(i % 2 == 0) || pr_gnt !== 1'(i % 2 == 1)) begin
                errors++;
                $display("FAIL rr_seq cyc %0d got wr%b pr%b exp wr%b pr%b", i, wr_gnt, pr_gnt,
                         (i % 2 == 0), (i % 2 == 1));
            end
        end
        repeat (4) drive_cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic test_read_after_write();
        drive_cycle(1'b0, '0, 1'b1, ADDR_W'('h10), DATA_W'('h2A5), 1'b0, '0);
        checks++;
        if (wr_gnt !== 1'b1) begin
            errors++;
            $display("FAIL raw_wr_gnt got %b exp 1", wr_gnt);
        end
        drive_cycle(1'b0, '0, 1'b0, '0, '0, 1'b1, ADDR_W'('h10));
        checks++;
        if (pr_gnt !== 1'b1) begin
            errors++;
            $display("FAIL raw_pr_gnt got %b exp 1", pr_gnt);
        end
        for (int k = 1; k <= 3; k++) begin
            drive_cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
            checks++;
            if (pr_valid !== 1'(k == 3) || (k == 3 && pr_data !== DATA_W'('h2A5))) begin
                errors++;
                $display("FAIL raw_data gnt+%0d got %b/%h exp %b/2a5", k, pr_valid, pr_data, (k == 3));
            end
        end
    endtask

    task automatic test_random();
        logic          wp = 0, pp = 0;
        logic [ADDR_W-1:0] wa = '0, pa = '0;
        logic [DATA_W-1:0] wd = '0;
        logic          d;
        for (int i = 0; i < 400; i++) begin
            if (!wp) begin
                wp = 1'($urandom_range(0, 1));
                wa = ADDR_W'($urandom_range(0, 15));
                wd = DATA_W'($urandom);
            end
            if (!pp) begin
                pp = 1'($urandom_range(0, 1));
                pa = ADDR_W'($urandom_range(0, 15));
            end
            d = ($urandom_range(0, 9) < 3);
            drive_cycle(d, ADDR_W'($urandom_range(0, 15)), wp, wa, wd, pp, pa);
            checks++;
            if (wr_gnt !== e_wr_gnt || pr_gnt !== e_pr_gnt) begin
                errors++;
                $display("FAIL rand_gnt cyc %0d got %b%b exp %b%b", i, wr_gnt, pr_gnt, e_wr_gnt, e_pr_gnt);
            end
            checks++;
            if (bif.bram_en !== e_en || bif.bram_we !== e_we) begin
                errors++;
                $display("FAIL rand_cmd cyc %0d got en%b we%b exp en%b we%b", i, bif.bram_en, bif.bram_we,
                         e_en, e_we);
            end
            checks++;
            if (disp_valid !== e_disp_valid || disp_data !== e_disp_data ||
                pr_valid !== e_pr_valid || pr_data !== e_pr_data) begin
                errors++;
                $display("FAIL rand_ret cyc %0d got d%b/%h p%b/%h exp d%b/%h p%b/%h", i, disp_valid, disp_data,
                         pr_valid, pr_data, e_disp_valid, e_disp_data, e_pr_valid, e_pr_data);
            end
            if (e_wr_gnt) wp = 1'b0;
            if (e_pr_gnt) pp = 1'b0;
        end
        repeat (4) drive_cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic test_reset_midflight();
        drive_cycle(1'b0, '0, 1'b0, '0, '0, 1'b1, ADDR_W'('h33));
        checks++;
        if (pr_gnt !== 1'b1) begin
            errors++;
            $display("FAIL mid_pr_gnt got %b exp 1", pr_gnt);
        end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        model_reset();
        for (int k = 0; k < 9; k++) begin
            if (k == 3) reset = 1'b1;
            #1;
            checks++;
            if ({disp_valid, pr_valid, wr_gnt, pr_gnt, bif.bram_en, bif.bram_we} !== 6'b0 ||
                disp_data !== '0 || pr_data !== '0 || bif.bram_addr !== '0 || bif.bram_wdata !== '0) begin
                errors++;
                $display("FAIL mid_reset step %0d got v%b%b en%b we%b d%h p%h a%h w%h exp all 0", k,
                         disp_valid, pr_valid, bif.bram_en, bif.bram_we, disp_data, pr_data,
                         bif.bram_addr, bif.bram_wdata);
            end
            @(negedge clk);
        end
    endtask

`ifdef FRAME_BUFFER_ARB_STATS_EN
    task automatic test_stats();
        apply_reset(2);
        disp_req = 1'b1;
        wr_req   = 1'b1;
        wr_addr  = ADDR_W'('h7);
        repeat (100) @(negedge clk);
        #1;
        checks++;
        if (stat_wr_stall !== 16'd100 || stat_pr_stall !== 16'd0) begin
            errors++;
            $display("FAIL stat_count got %0d/%0d exp 100/0", stat_wr_stall, stat_pr_stall);
        end
        repeat (70000) @(negedge clk);
        #1;
        checks++;
        if (stat_wr_stall !== 16'hFFFF) begin
            errors++;
            $display("FAIL stat_sat got %h exp ffff", stat_wr_stall);
        end
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (stat_wr_stall !== 16'hFFFF || stat_pr_stall !== 16'd0) begin
            errors++;
            $display("FAIL stat_hold got %h/%h exp ffff/0000", stat_wr_stall, stat_pr_stall);
        end
        apply_reset(2);
        #1;
        checks++;
        if (stat_wr_stall !== 16'd0) begin
            errors++;
            $display("FAIL stat_clear got %h exp 0000", stat_wr_stall);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_display_only();
        test_contention();
        test_round_robin();
        test_read_after_write();
        test_random();
        test_reset_midflight();
`ifdef FRAME_BUFFER_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_buffer_arbiter.md
# frame_buffer_arbiter

- Shares the single port of the frame-buffer BRAM among three requesters:
  - the VGA display reader (the read path that feeds the output interface);
  - the filter write-back client;
  - the filter read (processing) client.
- The display reader has absolute priority so scan-out never stalls. The two filter clients share the remaining cycles round-robin.
- The block sits between the requesters and the BRAM primitive. It sequences every BRAM command and routes read data back to its owner with a tag pipeline.

## Interface

Parameters:
- ADDR_W, 19, BRAM address width.
- DATA_W, 18, pixel width (6 bits per colour).
- BRAM_LATENCY, 1, BRAM read latency in cycles; legal range 1..3.

Ports:
- clk  in  1  pixel clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- disp_req  in  1  display read request this cycle; always granted.
- disp_addr  in  ADDR_W  display read address.
- disp_data  out  DATA_W  display read data.
- disp_valid  out  1  disp_data valid.
- wr_req  in  1  write request; held with wr_addr/wr_data until wr_gnt.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_gnt  out  1  write accepted this cycle; combinational.
- pr_req  in  1  processing read request; held with pr_addr until pr_gnt.
- pr_addr  in  ADDR_W  processing read address.
- pr_gnt  out  1  processing read accepted this cycle; combinational.
- pr_data  out  DATA_W  processing read data.
- pr_valid  out  1  pr_data valid.
- bram_en, bram_we  out  1  BRAM enable and write enable.
- bram_addr  out  ADDR_W  BRAM address.
- bram_wdata  out  DATA_W  BRAM write data.
- bram_rdata  in  DATA_W  BRAM read data.

## Operation

Arbitration (combinational, cycle t), in priority order:
- disp_req=1 → display wins; wr_gnt=pr_gnt=0.
- Otherwise only one of wr_req/pr_req set → that client is granted.
- Otherwise both set → the client not served last wins (round-robin pointer `rr_last`, values WR/PR).
- `rr_last` updates only on a wr or pr grant. Display grants leave it unchanged.

Command stage: a registered owner FSM `cmd_owner` with states IDLE, DISP, WR, PR.
- Next state = winner of cycle t, or IDLE when there are no requests.
- bram_en, bram_we, bram_addr and bram_wdata are registered from the winner.
  - bram_we=1 only in WR.
  - bram_wdata holds its previous value when not in WR.

Return path:
- A tag shift register of depth BRAM_LATENCY carries the owner (DISP/PR/none) of each read.
- On tag exit, bram_rdata is registered into disp_data or pr_data, and the matching valid pulses for 1 cycle.
- A WR command produces no tag.
- Data outputs hold their last value while the matching valid=0.

Ordering: all commands reach BRAM in grant order through one port. A pr read granted after a wr_gnt to the same address returns the new data.

## Timing

- Grant: same cycle as the request (cycle t).
- BRAM command visible at t+1.
- Read data at t+2+BRAM_LATENCY (3 cycles for the default). Back-to-back grants give one result per cycle.
- Reset values: all outputs 0, `cmd_owner`=IDLE, `rr_last`=PR (so WR wins the first tie), tag pipeline cleared.
- Reset mid-operation: in-flight tags are discarded; no valid is ever asserted for commands issued before reset.
- disp_req held continuously starves wr/pr indefinitely. This is required behaviour; clients must tolerate unbounded wait.
- A client dropping its request before being granted is a protocol violation and is not checked.
- No address range checking.

## Configuration

FRAME_BUFFER_ARB_STATS_EN:
- Defined: adds outputs stat_wr_stall and stat_pr_stall (16 bits each).
  - Each counts cycles with req=1 and gnt=0.
  - Counters saturate at 16'hFFFF.
  - Cleared by reset.
- Undefined: ports and counters are absent; arbitration behaviour is identical.

## Structure

- Package `frame_buffer_pkg` holds:
  - the `owner_t` enum (IDLE, DISP, WR, PR);
  - default ADDR_W and DATA_W constants, shared with the output interface.
- One sub-module, `rd_tag_pipe`: a parameterised tag shift register (depth BRAM_LATENCY) that also captures the data.

## Test plan

- Display only: disp_req every cycle, addresses 0..9, BRAM model returns addr+100 → disp_valid continuous from cycle 3, data 100..109 in order.
- Contention: disp_req=1 and wr_req=1 for 5 cycles, then disp_req=0 → wr_gnt=0 for 5 cycles, then 1 on cycle 6; exactly one bram_we pulse.
- Round-robin: wr_req and pr_req held with no display → grants alternate WR,PR,WR,PR starting with WR after reset.
- Read-after-write: wr addr 0x10 data 0x2A5, then pr read of 0x10 → pr_valid 3 cycles after pr_gnt with pr_data=0x2A5.
- Reset mid-flight: assert reset 1 cycle after a pr_gnt → pr_valid stays 0, all outputs 0 during and after reset until new requests.
- With FRAME_BUFFER_ARB_STATS_EN: wr stalled 70000 cycles → stat_wr_stall=16'hFFFF and holds.
